// File: rtl/router_dst_rd_sched.sv
// Round-robin read scheduler: drains one packet at a time from the per-port FIFOs
// into a ready/valid sink. Optional parity check is enabled by defining PARITY_CHECK_EN.
module router_dst_rd_sched #(
  parameter int unsigned NPORT       = 3,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 30
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NPORT-1:0]          vld_out,
  input  logic [NPORT*DATA_W-1:0]   data_out,
  output logic [NPORT-1:0]          read_enb,
  output logic [DATA_W-1:0]         snk_data,
  output logic                      snk_valid,
  input  logic                      snk_ready,
  output logic                      snk_last,
  output logic [$clog2(NPORT)-1:0]  snk_port,
  output logic                      pkt_done,
  output logic                      parity_err,
  output logic                      timeout_err
);

  localparam int unsigned PW = $clog2(NPORT);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, HDR, HWAIT, BODY, DRAIN} state_t;

  state_t            state;
  logic [PW-1:0]     ptr, g, gnt_idx, nxt_ptr;
  logic              gnt_hit;
  logic [6:0]        bytes_left;
  logic [TW-1:0]     to_cnt;
  logic              inflight, inflight_last;
  logic [DATA_W-1:0] buf_data [2];
  logic [1:0]        buf_last;
  logic [1:0]        buf_count;
  logic              vld_g, rd, pop, push, wr_sel, to_low, to_fire, done_fire;
  logic [DATA_W-1:0] in_data;

  always_comb begin
    vld_g   = 1'b0;
    in_data = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (g == PW'(p)) begin
        vld_g   = vld_out[p];
        in_data = data_out[p*DATA_W +: DATA_W];
      end
    end
  end

  // First pass covers ports at/after the pointer, second pass wraps to port 0.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    for (int unsigned j = 0; j < NPORT; j++) begin
      if (!gnt_hit && vld_out[j] && (PW'(j) >= ptr)) begin
        gnt_hit = 1'b1;
        gnt_idx = PW'(j);
      end
    end
    for (int unsigned j = 0; j < NPORT; j++) begin
      if (!gnt_hit && vld_out[j]) begin
        gnt_hit = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  always_comb begin
    rd = ((state == HDR) || (state == BODY)) && vld_g && (bytes_left != '0) &&
         (({1'b0, buf_count} + {2'b0, inflight}) < 3'd2);
    for (int unsigned p = 0; p < NPORT; p++) begin
      read_enb[p] = rd && (g == PW'(p));
    end
  end

  assign snk_data  = buf_data[0];
  assign snk_valid = (buf_count != 2'd0);
  assign snk_last  = snk_valid && buf_last[0];
  assign snk_port  = g;

  assign pop       = snk_valid && snk_ready;
  assign push      = inflight;
  assign wr_sel    = ((buf_count == 2'd1) && !pop) || (buf_count == 2'd2);
  assign nxt_ptr   = (g == PW'(NPORT - 1)) ? '0 : g + 1'b1;
  assign to_low    = ((state == HWAIT) || (state == BODY)) && !vld_g && (bytes_left != '0);
  assign to_fire   = to_low && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign done_fire = (state == DRAIN) && pop && (buf_count == 2'd1) && !inflight && buf_last[0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      ptr           <= '0;
      g             <= '0;
      bytes_left    <= '0;
      to_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      pkt_done      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      pkt_done      <= 1'b0;
      timeout_err   <= 1'b0;
      inflight      <= rd;
      inflight_last <= rd && (state == BODY) && (bytes_left == 7'd1);
      to_cnt        <= to_low ? to_cnt + 1'b1 : '0;
      unique case (state)
        IDLE: if (gnt_hit) begin
          g          <= gnt_idx;
          bytes_left <= 7'd1;
          state      <= HDR;
        end
        HDR: if (rd) begin
          bytes_left <= bytes_left - 7'd1;
          state      <= HWAIT;
        end
        HWAIT: if (inflight) begin
          bytes_left <= {1'b0, in_data[7:2]} + 7'd1;
          state      <= BODY;
        end
        BODY: if (rd) begin
          bytes_left <= bytes_left - 7'd1;
          if (bytes_left == 7'd1) state <= DRAIN;
        end
        DRAIN: if (done_fire) begin
          state    <= IDLE;
          ptr      <= nxt_ptr;
          pkt_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (to_fire) begin
        state       <= IDLE;
        ptr         <= nxt_ptr;
        timeout_err <= 1'b1;
        inflight    <= 1'b0;
        to_cnt      <= '0;
        bytes_left  <= '0;
      end
    end
  end

  // Two-entry skid buffer; head is always entry 0 and shifts down on accept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      buf_count   <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
    end else if (to_fire) begin
      buf_count <= '0;
    end else begin
      if (pop) begin
        buf_data[0] <= buf_data[1];
        buf_last[0] <= buf_last[1];
      end
      if (push) begin
        buf_data[wr_sel] <= in_data;
        buf_last[wr_sel] <= inflight_last;
      end
      buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef PARITY_CHECK_EN
  logic [DATA_W-1:0] par_acc;
  logic              par_bad;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      par_acc    <= '0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= done_fire && par_bad;
      if (state == IDLE) begin
        par_acc <= '0;
        par_bad <= 1'b0;
      end else if (push) begin
        if (inflight_last) par_bad <= (par_acc != in_data);
        else               par_acc <= par_acc ^ in_data;
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_dst_rd_sched.sv
// Scoreboard bench for router_dst_rd_sched: FIFO model drives the ports, a monitor
// checks every accepted sink byte, pkt_done/parity_err and the per-cycle invariants.
module tb_router_dst_rd_sched;

`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic [2:0]  vld_out;
  logic [23:0] data_out;
  logic [2:0]  read_enb;
  logic [7:0]  snk_data;
  logic        snk_valid, snk_ready, snk_last;
  logic [1:0]  snk_port;
  logic        pkt_done, parity_err, timeout_err;

  always #5 clock = ~clock;

  router_dst_rd_sched #(.NPORT(3), .DATA_W(8), .TIMEOUT_CYC(8)) dut (
    .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out),
    .read_enb(read_enb), .snk_data(snk_data), .snk_valid(snk_valid),
    .snk_ready(snk_ready), .snk_last(snk_last), .snk_port(snk_port),
    .pkt_done(pkt_done), .parity_err(parity_err), .timeout_err(timeout_err)
  );

  typedef struct packed {logic [7:0] d; logic last; logic [1:0] port;} beat_t;

  beat_t      exp_q[$];
  logic       exp_done_q[$];
  logic [7:0] fq0[$], fq1[$], fq2[$];
  int         checks = 0, errors = 0, seen_to = 0, ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fifo_push(input int p, input logic [7:0] b);
    case (p)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  task automatic push_byte(input int p, input logic [7:0] b, input logic last);
    fifo_push(p, b);
    exp_q.push_back('{d: b, last: last, port: 2'(p)});
  endtask

  function automatic logic [7:0] pay(input int i);
    return 8'((48 + 17 * i) % 256);
  endfunction

  // nsend < 0 pushes the whole packet; otherwise only the first nsend bytes reach the FIFO.
  task automatic send_pkt(input int p, input int len, input bit bad, input int nsend);
    logic [7:0] b[$];
    logic [7:0] par, x;
    int n;
    par = {len[5:0], 2'(p)};
    b.push_back(par);
    for (int i = 0; i < len; i++) begin
      x = pay(i);
      par ^= x;
      b.push_back(x);
    end
    if (bad) par = ~par;
    b.push_back(par);
    n = (nsend < 0) ? b.size() : nsend;
    for (int i = 0; i < n; i++) push_byte(p, b[i], i == b.size() - 1);
    if (n == b.size()) exp_done_q.push_back(bad & PAR_EN);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("drain_budget", (exp_q.size() == 0 && exp_done_q.size() == 0), 1);
    repeat (2) @(negedge clock);
  endtask

  // FIFO model: a read strobe seen during a cycle pops the byte just after that edge.
  initial begin
    logic [2:0] re_s;
    vld_out = '0; data_out = '0; snk_ready = 1'b1;
    forever begin
      @(negedge clock);
      re_s = read_enb;
      @(posedge clock);
      #1;
      if (re_s[0]) begin chk("fifo0_nonempty", fq0.size() != 0, 1); if (fq0.size() != 0) data_out[7:0]   = fq0.pop_front(); end
      if (re_s[1]) begin chk("fifo1_nonempty", fq1.size() != 0, 1); if (fq1.size() != 0) data_out[15:8]  = fq1.pop_front(); end
      if (re_s[2]) begin chk("fifo2_nonempty", fq2.size() != 0, 1); if (fq2.size() != 0) data_out[23:16] = fq2.pop_front(); end
      vld_out = {fq2.size() != 0, fq1.size() != 0, fq0.size() != 0};
      case (ready_mode)
        0: snk_ready = 1'b1;
        1: snk_ready = ~snk_ready;
        default: snk_ready = 1'b0;
      endcase
    end
  end

  initial begin
    beat_t e, prev;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        prev_stall = 1'b0;
      end else begin
        chk("read_enb_onehot0", $onehot0(read_enb), 1);
        chk("occupancy_le2", (32'(dut.buf_count) + 32'(dut.inflight)) <= 2, 1);
        if (prev_stall) begin
          chk("stall_hold", {snk_valid, snk_data, snk_last}, {1'b1, prev.d, prev.last});
        end
        if (snk_valid && snk_ready) begin
          chk("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", {snk_data, snk_last, snk_port}, {e.d, e.last, e.port});
          end
        end
        prev_stall = snk_valid && !snk_ready;
        prev = '{d: snk_data, last: snk_last, port: snk_port};
        if (pkt_done) begin
          chk("done_expected", exp_done_q.size() != 0, 1);
          if (exp_done_q.size() != 0) chk("parity_err", parity_err, exp_done_q.pop_front());
        end else begin
          chk("parity_err_idle", parity_err, 0);
        end
        if (timeout_err) seen_to++;
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_outputs", {read_enb, snk_valid, snk_last, pkt_done, parity_err, timeout_err, snk_data, snk_port}, '0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Port 1, len 3: parity 0D^AA^BB^CC = D0; header expected on sink at T+3.
    push_byte(1, 8'h0D, 1'b0); push_byte(1, 8'hAA, 1'b0); push_byte(1, 8'hBB, 1'b0);
    push_byte(1, 8'hCC, 1'b0); push_byte(1, 8'hD0, 1'b1);
    exp_done_q.push_back(1'b0);
    @(posedge clock); #2;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("hdr_not_before_T3", snk_valid, 0);
    @(posedge clock);
    @(negedge clock);
    chk("hdr_at_T3", {snk_valid, snk_data, snk_port}, {1'b1, 8'h0D, 2'd1});
    wait_drain(100);

    // Corrupted parity on port 2 (pointer now 2).
    send_pkt(2, 2, 1'b1, -1);
    wait_drain(100);

    // Three len-2 packets pending at once: pointer 0 -> served 0,1,2.
    send_pkt(0, 2, 1'b0, -1);
    send_pkt(1, 2, 1'b0, -1);
    send_pkt(2, 2, 1'b0, -1);
    wait_drain(200);
    send_pkt(0, 1, 1'b0, -1);
    send_pkt(1, 1, 1'b0, -1);
    wait_drain(200);

    // Len 10 with toggling sink ready.
    ready_mode = 1;
    send_pkt(2, 10, 1'b0, -1);
    wait_drain(300);
    ready_mode = 0;
    @(negedge clock);

    // Port 2 stalls after 3 of 6 bytes; pending port 0 must win next.
    send_pkt(2, 4, 1'b0, 3);
    repeat (4) @(negedge clock);
    send_pkt(0, 1, 1'b0, -1);
    n = 0;
    while (seen_to == 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_seen", seen_to, 1);
    wait_drain(100);

    // Boundaries: max length on port 0, then zero length on port 1 (pointer -> 2).
    send_pkt(0, 63, 1'b0, -1);
    wait_drain(400);
    send_pkt(1, 0, 1'b0, -1);
    wait_drain(100);

    // Reset mid-BODY on port 0 while a read strobe is active.
    send_pkt(0, 20, 1'b0, -1);
    repeat (8) @(posedge clock);
    n = 0;
    @(posedge clock); #2;
    while (read_enb == '0 && n < 50) begin
      @(posedge clock); #2;
      n++;
    end
    chk("pre_reset_reading", read_enb != '0, 1);
    resetn = 1'b0;
    #1;
    chk("reset_async_outputs", {read_enb, snk_valid}, '0);
    exp_q.delete();
    exp_done_q.delete();
    fq0.delete();
    repeat (2) @(negedge clock);
    chk("reset_hold_outputs", {read_enb, snk_valid, pkt_done, timeout_err}, '0);
    resetn = 1'b1;
    @(negedge clock);
    send_pkt(1, 1, 1'b0, -1);
    send_pkt(2, 1, 1'b0, -1);
    wait_drain(200);

    chk("timeout_total", seen_to, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
